leb128_stream_decoder: RTL and testbench

//  Byte-serial LEB128 decoder, parametrised in result width and signedness.

---
 rtl/leb128_pkg.sv | 26 ++
 rtl/leb128_sign_ext.sv | 52 +++++
 rtl/leb128_stream_decoder.sv | 130 +++++++++++++
 tb/tb_leb128_stream_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leb128_pkg.sv
// -----------------------------------------------------------------------------
// leb128_pkg
// Shared definitions for the LEB128 decoder (and any future encoder):
//   - state_t      : decoder FSM states (accumulate, skip overlong tail, output)
//   - leb128_maxb  : maximum legal bytes per encoding for a W-bit result
//   - leb128_lw    : width of a byte counter that can hold 0..MAXB+1
// -----------------------------------------------------------------------------
package leb128_pkg;

   typedef enum logic [1:0] {
      S_ACC  = 2'd0,
      S_SKIP = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   // ceil(w/7): every byte carries 7 payload bits
   function automatic int leb128_maxb(input int w);
      return (w + 6) / 7;
   endfunction

   // Counter must reach MAXB+1 (the saturated overlong length)
   function automatic int leb128_lw(input int w);
      return $clog2(leb128_maxb(w) + 2);
   endfunction

endpackage

// File: rtl/leb128_sign_ext.sv
// -----------------------------------------------------------------------------
// leb128_sign_ext
// Combinational finishing stage for the terminating byte of an encoding.
// Ports:
//   i_acc   [W]   accumulator with the terminating chunk already merged in
//   i_cnt   [LW]  total bytes of this encoding, including the terminating one
//   i_chunk [7]   payload bits of the terminating byte
//   o_value [W]   i_acc, sign-extended above bit 7*i_cnt when SIGNED and chunk bit6
//   o_ovf         terminating byte at index MAXB-1 carries bits that do not fit W
// -----------------------------------------------------------------------------
module leb128_sign_ext
   import leb128_pkg::*;
#(
   parameter int W      = 64,
   parameter int SIGNED = 0,
   parameter int MAXB   = leb128_maxb(W),
   parameter int LW     = leb128_lw(W)
) (
   input  logic [W-1:0]  i_acc,
   input  logic [LW-1:0] i_cnt,
   input  logic [6:0]    i_chunk,
   output logic [W-1:0]  o_value,
   output logic          o_ovf
);

   // Position, inside the last legal chunk, of result bit W-1
   localparam int TOPPOS = W - 1 - 7 * (MAXB - 1);

   always_comb begin
      o_value = i_acc;
      // Fill every bit at or above 7*cnt; nothing to do once 7*cnt >= W
      if (SIGNED != 0 && i_chunk[6]) begin
         for (int b = 0; b < W; b++) begin
            if (b >= 7 * int'(i_cnt)) o_value[b] = 1'b1;
         end
      end

      // Chunk bits above TOPPOS fall outside W: unsigned needs them zero,
      // signed needs them to replicate the result's sign bit.
      o_ovf = 1'b0;
      if (int'(i_cnt) == MAXB) begin
         for (int j = TOPPOS + 1; j < 7; j++) begin
            if (SIGNED != 0) begin
               if (i_chunk[j] != i_chunk[TOPPOS]) o_ovf = 1'b1;
            end else begin
               if (i_chunk[j]) o_ovf = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/leb128_stream_decoder.sv
// -----------------------------------------------------------------------------
// leb128_stream_decoder
// Byte-serial ULEB128/SLEB128 decoder. One encoded byte per cycle in, one
// decoded word per terminated encoding out.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data  [8]    encoded byte (bit7 continuation, bits6:0 payload)
//   in_valid/ready  input byte handshake
//   out_data [W]    decoded value (meaningless when out_err=1)
//   out_len  [LW]   bytes of this encoding, saturating at MAXB+1
//   out_err         overlong encoding or value does not fit W
//   out_valid/ready result handshake
//   dbg_state [2]   current FSM state (state_t encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its data until that edge. in_ready depends
// only on the registered state, never on out_ready.
// -----------------------------------------------------------------------------
module leb128_stream_decoder
   import leb128_pkg::*;
#(
   parameter int W      = 64,
   parameter int SIGNED = 0,
   parameter int MAXB   = leb128_maxb(W),
   parameter int LW     = leb128_lw(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  out_data,
   output logic [LW-1:0] out_len,
   output logic          out_err,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    dbg_state
);

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_acc, w_acc_nxt;
   logic [LW-1:0] r_cnt, w_cnt_nxt;
   logic          r_err, w_err_nxt;

   logic [W-1:0]  w_chunk_pos;
   logic [W-1:0]  w_merged;
   logic [W-1:0]  w_ext;
   logic [LW-1:0] w_cnt_inc;
   logic          w_ovf;

   // Payload bits shifted past W are dropped by the W-bit result
   assign w_chunk_pos = W'(in_data[6:0]) << (7 * int'(r_cnt));
   assign w_merged    = r_acc | w_chunk_pos;
   assign w_cnt_inc   = r_cnt + LW'(1);

   leb128_sign_ext #(
      .W      (W),
      .SIGNED (SIGNED),
      .MAXB   (MAXB),
      .LW     (LW)
   ) u_sign_ext (
      .i_acc   (w_merged),
      .i_cnt   (w_cnt_inc),
      .i_chunk (in_data[6:0]),
      .o_value (w_ext),
      .o_ovf   (w_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      case (r_state)
         S_ACC: begin
            if (in_valid) begin
               w_cnt_nxt = w_cnt_inc;
               if (!in_data[7]) begin
                  w_acc_nxt   = w_ext;
                  w_err_nxt   = w_ovf;
                  w_state_nxt = S_OUT;
               end else begin
                  w_acc_nxt = w_merged;
                  // Continuation on the last legal byte: encoding is overlong
                  if (int'(w_cnt_inc) == MAXB) begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_SKIP;
                  end
               end
            end
         end
         S_SKIP: begin
            if (in_valid) begin
               if (int'(r_cnt) != MAXB + 1) w_cnt_nxt = w_cnt_inc;
               if (!in_data[7]) w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_ACC;
            end
         end
         default: w_state_nxt = S_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ACC;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign in_ready  = (r_state != S_OUT);
   assign out_valid = (r_state == S_OUT);
   assign out_data  = r_acc;
   assign out_len   = r_cnt;
   assign out_err   = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_leb128_stream_decoder
// Drives one byte stream into an unsigned and a signed 64-bit decoder in
// parallel and compares every result against a value-level LEB128 model.
// -----------------------------------------------------------------------------
module tb_leb128_stream_decoder;

  localparam int W    = 64;
  localparam int MAXB = 10;
  localparam int LW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          out_ready;

  logic          u_in_ready, s_in_ready;
  logic [W-1:0]  u_out_data, s_out_data;
  logic [LW-1:0] u_out_len, s_out_len;
  logic          u_out_err, s_out_err;
  logic          u_out_valid, s_out_valid;
  logic [1:0]    u_dbg, s_dbg;

  leb128_stream_decoder #(.W(W), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(u_in_ready), .out_data(u_out_data), .out_len(u_out_len),
    .out_err(u_out_err), .out_valid(u_out_valid), .out_ready(out_ready),
    .dbg_state(u_dbg)
  );

  leb128_stream_decoder #(.W(W), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_len(s_out_len),
    .out_err(s_out_err), .out_valid(s_out_valid), .out_ready(out_ready),
    .dbg_state(s_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  bit mon_hold = 1'b1;

  logic [W-1:0] exp_du_q[$];
  logic [W-1:0] exp_ds_q[$];
  int           exp_len_q[$];
  bit           exp_eu_q[$];
  bit           exp_es_q[$];

  logic [7:0]   enc_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [63:0] du, input logic [63:0] ds, input int len,
                          input bit eu, input bit es);
    exp_du_q.push_back(du);
    exp_ds_q.push_back(ds);
    exp_len_q.push_back(len);
    exp_eu_q.push_back(eu);
    exp_es_q.push_back(es);
  endtask

  // Value-level model: assemble the full mathematical value in 80 bits and
  // ask whether it fits the 64-bit unsigned / signed range.
  task automatic push_model();
    int n;
    int len;
    logic [79:0] big;
    logic [79:0] bs;
    bit eu;
    bit es;
    n   = enc_q.size();
    len = (n > MAXB) ? MAXB + 1 : n;
    big = '0;
    bs  = '0;
    if (n > MAXB) begin
      eu = 1'b1;
      es = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) big = big | ({73'd0, enc_q[i][6:0]} << (7 * i));
      bs = big;
      if (enc_q[n-1][6]) bs = big | ({80{1'b1}} << (7 * n));
      eu = (big[79:64] != 16'd0);
      es = !((&bs[79:63]) || !(|bs[79:63]));
    end
    push_exp(big[63:0], bs[63:0], len, eu, es);
  endtask

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!u_in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!u_in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_enc(input int max_gap);
    for (int i = 0; i < enc_q.size(); i++) begin
      send_byte(enc_q[i]);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_len_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_len_q.size() != 0) check_val("drain_timeout", 64'(exp_len_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- result monitor / consumer ----------------
  initial begin
    logic [W-1:0] du, ds;
    int  len;
    bit  eu, es;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_ready = 1'b0;
      end else begin
        out_ready = mon_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (u_out_valid && out_ready) begin
          if (exp_len_q.size() == 0) begin
            check_val("unexpected_out", 64'd1, 64'd0);
          end else begin
            du  = exp_du_q.pop_front();
            ds  = exp_ds_q.pop_front();
            len = exp_len_q.pop_front();
            eu  = exp_eu_q.pop_front();
            es  = exp_es_q.pop_front();
            check_val("s_valid", 64'(s_out_valid), 64'd1);
            check_val("u_len", 64'(u_out_len), 64'(len));
            check_val("s_len", 64'(s_out_len), 64'(len));
            check_val("u_err", 64'(u_out_err), 64'(eu));
            check_val("s_err", 64'(s_out_err), 64'(es));
            if (!eu) check_val("u_data", u_out_data, du);
            if (!es) check_val("s_data", s_out_data, ds);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog expired, pending=%0d", exp_len_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, r;
    logic [7:0] lb;
    logic [7:0] picks [4];
    picks = '{8'h00, 8'h01, 8'h7F, 8'h7E};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 64'(u_out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_state", 64'(u_dbg), 64'd0);
    check_val("rst_in_ready", 64'(u_in_ready), 64'd1);
    check_val("rst_out_valid", 64'(s_out_valid), 64'd0);
    check_val("rst_out_data", u_out_data, 64'd0);
    check_val("rst_out_len", 64'(u_out_len), 64'd0);
    check_val("rst_out_err", 64'(u_out_err), 64'd0);
    mon_hold = 1'b0;

    // 624485, one-cycle latency after the terminating byte
    enc_q = '{8'hE5, 8'h8E, 8'h26};
    push_exp(64'd624485, 64'd624485, 3, 1'b0, 1'b0);
    send_enc(0);
    check_val("lat_valid", 64'(u_out_valid), 64'd1);
    check_val("lat_in_ready", 64'(u_in_ready), 64'd0);
    wait_drain();

    // -123456 signed, and single-byte -1
    enc_q = '{8'hC0, 8'hBB, 8'h78};
    push_exp(64'd1973696, 64'hFFFF_FFFF_FFFE_1DC0, 3, 1'b0, 1'b0);
    send_enc(0);
    enc_q = '{8'h7F};
    push_exp(64'd127, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0);
    send_enc(0);

    // 10-byte boundary: fits unsigned, overflows signed; then overflow both
    enc_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 10, 1'b0, 1'b1);
    send_enc(1);
    enc_q[9] = 8'h03;
    push_exp(64'd0, 64'd0, 10, 1'b1, 1'b1);
    send_enc(1);

    // Overlong with saturating length, then recovery
    enc_q = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    push_exp(64'd0, 64'd0, 11, 1'b1, 1'b1);
    send_enc(0);
    enc_q = '{8'h05};
    push_exp(64'd5, 64'd5, 1, 1'b0, 1'b0);
    send_enc(0);
    wait_drain();

    // Backpressure: result held for 5 cycles, then back-to-back
    mon_hold = 1'b1;
    enc_q = '{8'h2A};
    push_exp(64'd42, 64'd42, 1, 1'b0, 1'b0);
    send_enc(0);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_in_ready", 64'(u_in_ready), 64'd0);
      check_val("bp_valid", 64'(u_out_valid), 64'd1);
      check_val("bp_data", u_out_data, 64'd42);
      check_val("bp_len", 64'(u_out_len), 64'd1);
      @(negedge clk);
    end
    mon_hold = 1'b0;
    enc_q = '{8'h01, 8'h02, 8'h03};
    push_exp(64'd1, 64'd1, 1, 1'b0, 1'b0);
    push_exp(64'd2, 64'd2, 1, 1'b0, 1'b0);
    push_exp(64'd3, 64'd3, 1, 1'b0, 1'b0);
    send_enc(0);
    wait_drain();

    // Reset mid-encoding discards the partial value
    send_byte(8'h80);
    send_byte(8'h80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enc_q = '{8'h2A};
    push_exp(64'd42, 64'd42, 1, 1'b0, 1'b0);
    send_enc(0);
    wait_drain();

    // Reset while a result is pending drops it
    mon_hold = 1'b1;
    enc_q = '{8'h05};
    push_exp(64'd5, 64'd5, 1, 1'b0, 1'b0);
    send_enc(0);
    check_val("pre_rst_valid", 64'(u_out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_out_drop", 64'(u_out_valid), 64'd0);
    check_val("rst_out_state", 64'(s_dbg), 64'd0);
    rst = 1'b0;
    void'(exp_du_q.pop_back());
    void'(exp_ds_q.pop_back());
    void'(exp_len_q.pop_back());
    void'(exp_eu_q.pop_back());
    void'(exp_es_q.pop_back());
    @(negedge clk);
    mon_hold = 1'b0;

    // Randomized encodings against the model
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      n = $urandom_range(1, 9);
      else if (r < 88) n = 10;
      else             n = $urandom_range(11, 13);
      enc_q.delete();
      for (int i = 0; i < n; i++) enc_q.push_back(8'($urandom_range(0, 255)) | 8'h80);
      lb = 8'($urandom_range(0, 127));
      if (n == 10 && $urandom_range(0, 1) == 1) lb = picks[$urandom_range(0, 3)];
      enc_q[n-1] = lb;
      push_model();
      send_enc(2);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
